// File: rtl/plu_controller.sv
// Sequencing controller for the 4-lane PLU multiply/add/ReLU datapath.
// Runs a batch of activation vectors through a 4-deep pipeline with a global stall.
module plu_controller #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             w_load,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             w_we,
    output logic             a_we,
    output logic             r1_we,
    output logic             r2_we,
    output logic             r3_we,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] issued;
    logic             vld_p0, vld_p1, vld_p2, vld_p3;
    logic             adv;
    logic             retire;

    always_comb begin
        adv       = !vld_p3 || out_ready;
        in_ready  = (state == RUN) && (issued < num_lat) && adv;
        a_we      = in_valid && in_ready;
        r1_we     = adv && vld_p0;
        r2_we     = adv && vld_p1;
        r3_we     = adv && vld_p2;
        out_valid = vld_p3;
        retire    = vld_p3 && out_ready;
        // Gated by rst_n so a w_load held through reset never writes the weights.
        w_we      = rst_n && w_load && (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = (num_vec == '0) ? DONE : RUN;
            end
            RUN: begin
                if (a_we && (issued + CNT_W'(1) == num_lat)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (retire && (vec_count + CNT_W'(1) == num_lat)) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_lat   <= '0;
            issued    <= '0;
            vec_count <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                num_lat   <= num_vec;
                issued    <= '0;
                vec_count <= '0;
            end else begin
                if (a_we)   issued    <= issued + CNT_W'(1);
                if (retire) vec_count <= vec_count + CNT_W'(1);
            end
            // Global stall: every stage holds together when the output is blocked.
            if (adv) begin
                vld_p0 <= a_we;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
                vld_p3 <= vld_p2;
            end
        end
    end

endmodule
